// File: rtl/str_bus_rr_arbiter.sv
// Round-robin arbiter that funnels N_REQ valid/ready requesters onto one
// registered master-side bus. A beat is accepted from the winning requester
// in the same cycle it is offered. The beat is presented on bus_data/bus_valid
// from the next edge, and is held there until the slave returns bus_ready.
module str_bus_rr_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic [DATA_W-1:0]        bus_data,
   output logic                     bus_valid,
   input  logic                     bus_ready,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy
);

   localparam int ID_W = $clog2(N_REQ);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_HOLD = 1'b1;

   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
   localparam logic [ID_W:0]   N_WIDE  = (ID_W + 1)'(N_REQ);

   logic [0:0]          state;
   logic [0:0]          state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     ptr_nxt;
   logic [ID_W-1:0]     winner;
   logic                found;
   logic                load;
   logic [DATA_W-1:0]   win_data;
   logic [2*N_REQ-1:0]  rot_valid;
   logic [ID_W:0]       sum;

   // Round-robin search: rotate the request vector so that bit 0 is rr_ptr,
   // then take the first set bit and map its offset back to a requester index.
   always_comb begin
      rot_valid = {req_valid, req_valid} >> rr_ptr;
      found     = 1'b0;
      winner    = '0;
      sum       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && rot_valid[k]) begin
            found = 1'b1;
            sum   = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (sum >= N_WIDE) begin
               sum = sum - N_WIDE;
            end
            winner = sum[ID_W-1:0];
         end
      end
   end

   // A beat is taken whenever the output register is free or being emptied.
   // bus_ready is only meaningful while a beat is held.
   always_comb begin
      load = found && ((state == S_IDLE) || bus_ready);
   end

   // One-hot accept back to the winner and the winner's data for capture.
   // Accept is suppressed while reset is asserted so no handshake can leak.
   always_comb begin
      req_ready = '0;
      win_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (winner == ID_W'(i)) begin
            win_data     = req_data[i*DATA_W +: DATA_W];
            req_ready[i] = load && rst_n;
         end
      end
   end

   // Pointer moves to the slot after the winner, wrapping at the last requester.
   always_comb begin
      if (winner == LAST_ID) begin
         ptr_nxt = '0;
      end else begin
         ptr_nxt = winner + ID_W'(1);
      end
   end

   // Two-state control: HOLD while a beat sits in the output register.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (load) begin
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (bus_ready && !load) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register; reset drops any held beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Arbitration pointer advances only on loads, so requests that come and
   // go without a grant leave fairness untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (load) begin
         rr_ptr <= ptr_nxt;
      end
   end

   // Output beat register: data and source id are captured on a load and
   // otherwise retained, including after draining back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_data <= '0;
         grant_id <= '0;
      end else if (load) begin
         bus_data <= win_data;
         grant_id <= winner;
      end
   end

   assign bus_valid = (state == S_HOLD);
   assign busy      = bus_valid;

endmodule

// File: tb/tb_str_bus_rr_arbiter.sv
// Directed bench for str_bus_rr_arbiter (N_REQ=4, DATA_W=8): a table of
// per-cycle vectors followed by hand-written backpressure and async-reset
// sequences.
module tb_str_bus_rr_arbiter;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 8;

   localparam logic [31:0] DD  = 32'h1312_1110;
   localparam logic [31:0] DA  = 32'h13AA_1110;
   localparam logic [31:0] D55 = 32'h1312_1155;

   logic                    clk;
   logic                    rst_n;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]       bus_data;
   logic                    bus_valid;
   logic                    bus_ready;
   logic [1:0]              grant_id;
   logic                    busy;

   int checks = 0;
   int errors = 0;

   str_bus_rr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .bus_data  (bus_data),
      .bus_valid (bus_valid),
      .bus_ready (bus_ready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] data;
      logic        brdy;
      logic [3:0]  exp_ready;
      logic        exp_bv;
      logic [7:0]  exp_bd;
      logic [1:0]  exp_gid;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle: drive at negedge, check accept before the edge, check bus after it.
   task automatic run_cycle(input vec_t v);
      @(negedge clk);
      rst_n     = v.rst;
      req_valid = v.valid;
      req_data  = v.data;
      bus_ready = v.brdy;
      #1;
      check({v.name, ".req_ready"}, 32'(req_ready), 32'(v.exp_ready));
      @(posedge clk);
      #1;
      check({v.name, ".bus_valid"}, 32'(bus_valid), 32'(v.exp_bv));
      check({v.name, ".busy"},      32'(busy),      32'(v.exp_bv));
      check({v.name, ".bus_data"},  32'(bus_data),  32'(v.exp_bd));
      check({v.name, ".grant_id"},  32'(grant_id),  32'(v.exp_gid));
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      bus_ready = 1'b0;

      //                name          rst valid    data brdy ready    bv  bd     gid
      tbl.push_back('{"rst_hold",    0, 4'b1111, DD, 1, 4'b0000, 0, 8'h00, 2'd0});
      tbl.push_back('{"single",      1, 4'b0100, DA, 1, 4'b0100, 1, 8'hAA, 2'd2});
      tbl.push_back('{"drain",       1, 4'b0000, DD, 1, 4'b0000, 0, 8'hAA, 2'd2});
      tbl.push_back('{"idle_quiet",  1, 4'b0000, DD, 0, 4'b0000, 0, 8'hAA, 2'd2});
      tbl.push_back('{"wrap_skip1",  1, 4'b0010, DD, 0, 4'b0010, 1, 8'h11, 2'd1});
      tbl.push_back('{"hold_stall",  1, 4'b0100, DD, 0, 4'b0000, 1, 8'h11, 2'd1});
      tbl.push_back('{"to_ptr3",     1, 4'b0100, DD, 1, 4'b0100, 1, 8'h12, 2'd2});
      tbl.push_back('{"wrap_skip3",  1, 4'b1001, DD, 1, 4'b1000, 1, 8'h13, 2'd3});
      tbl.push_back('{"after_wrap",  1, 4'b1001, DD, 1, 4'b0001, 1, 8'h10, 2'd0});
      tbl.push_back('{"skip_to3",    1, 4'b1001, DD, 1, 4'b1000, 1, 8'h13, 2'd3});
      tbl.push_back('{"rst_again",   0, 4'b1111, DD, 1, 4'b0000, 0, 8'h00, 2'd0});
      tbl.push_back('{"rr0",         1, 4'b1111, DD, 1, 4'b0001, 1, 8'h10, 2'd0});
      tbl.push_back('{"rr1",         1, 4'b1111, DD, 1, 4'b0010, 1, 8'h11, 2'd1});
      tbl.push_back('{"rr2",         1, 4'b1111, DD, 1, 4'b0100, 1, 8'h12, 2'd2});
      tbl.push_back('{"rr3",         1, 4'b1111, DD, 1, 4'b1000, 1, 8'h13, 2'd3});
      tbl.push_back('{"rr4",         1, 4'b1111, DD, 1, 4'b0001, 1, 8'h10, 2'd0});
      tbl.push_back('{"rr_drain",    1, 4'b0000, DD, 1, 4'b0000, 0, 8'h10, 2'd0});

      foreach (tbl[i]) begin
         run_cycle(tbl[i]);
      end

      // Backpressure: beat 0x55 from requester 0 (pointer is at 1 here).
      run_cycle('{"bp_load", 1, 4'b0001, D55, 0, 4'b0001, 1, 8'h55, 2'd0});
      for (int c = 0; c < 5; c++) begin
         run_cycle('{$sformatf("bp_stall%0d", c), 1, 4'b0010, D55, 0, 4'b0000, 1, 8'h55, 2'd0});
      end
      run_cycle('{"bp_release", 1, 4'b0010, D55, 1, 4'b0010, 1, 8'h11, 2'd1});
      run_cycle('{"pre_rst_stall", 1, 4'b0010, D55, 0, 4'b0000, 1, 8'h11, 2'd1});

      // Reset mid-cycle while a beat is held and stalled: no clock edge needed.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async.bus_valid", 32'(bus_valid), 32'd0);
      check("async.busy",      32'(busy),      32'd0);
      check("async.grant_id",  32'(grant_id),  32'd0);
      check("async.bus_data",  32'(bus_data),  32'd0);
      check("async.req_ready", 32'(req_ready), 32'd0);

      run_cycle('{"rst_cycle", 0, 4'b1010, DD, 0, 4'b0000, 0, 8'h00, 2'd0});
      run_cycle('{"post_rst",  1, 4'b1010, DD, 0, 4'b0010, 1, 8'h11, 2'd1});
      run_cycle('{"post_rst2", 1, 4'b1010, DD, 1, 4'b1000, 1, 8'h13, 2'd3});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/str_bus_rr_arbiter.md
STR_BUS_RR_ARBITER -- requirements
Module: str_bus_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter DATA_W, default 8: bus data width in bits.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port req_valid  input  N_REQ: bit i set means requester i offers a beat.
REQ-006 Port req_data  input  N_REQ*DATA_W: requester i data in slice [i*DATA_W +: DATA_W].
REQ-007 Port req_ready  output  N_REQ: one-hot or zero; bit i set means requester i's beat is accepted this cycle.
REQ-008 Port bus_data  output  DATA_W: registered data driven to the shared bus (master side).
REQ-009 Port bus_valid  output  1: registered valid driven to the shared bus.
REQ-010 Port bus_ready  input  1: ready returned by the bus slave.
REQ-011 Port grant_id  output  $clog2(N_REQ): index of the requester whose beat is held in bus_data.
REQ-012 Port busy  output  1: equals bus_valid.

Function
REQ-013 The block SHALL use two states: IDLE (bus_valid=0) and HOLD (bus_valid=1).
REQ-014 Arbitration SHALL be round-robin. The search starts at pointer rr_ptr and wraps modulo N_REQ. The first i with req_valid[i]=1 wins.
REQ-015 A load occurs in either of these cases:
  - IDLE with any req_valid set;
  - HOLD with bus_ready=1 and any req_valid set.
REQ-016 On a load cycle the block SHALL do all of the following:
  - assert req_ready[winner] combinationally in that cycle;
  - on the next edge, capture req_data[winner] into bus_data;
  - on the next edge, set grant_id=winner and bus_valid=1;
  - on the next edge, set rr_ptr=(winner+1) mod N_REQ.
REQ-017 In HOLD with bus_ready=0, bus_data, grant_id and bus_valid SHALL stay stable and req_ready SHALL be all zero.
REQ-018 In HOLD with bus_ready=1 and no req_valid, the block SHALL clear bus_valid and enter IDLE. bus_data and grant_id SHALL retain their last values.
REQ-019 Back-to-back transfers SHALL run at full throughput: one beat per cycle when bus_ready is held at 1 and requests are pending.
REQ-020 Latency SHALL be one cycle from req_valid/req_ready handshake to bus_valid=1.
REQ-021 req_ready SHALL never have more than one bit set, and SHALL be zero when no load occurs.
REQ-022 rr_ptr SHALL change only on load cycles. Wrap: winner N_REQ-1 gives rr_ptr=0.
REQ-023 A requester that drops req_valid before being granted SHALL NOT be granted, and SHALL NOT affect rr_ptr.
REQ-024 bus_ready while in IDLE SHALL be ignored.
REQ-025 Starvation bound: a requester holding req_valid SHALL be granted within N_REQ loads.

Reset
REQ-026 While rst_n=0 the block SHALL hold all of the following, asynchronously and independent of clk:
  - state=IDLE, bus_valid=0, busy=0;
  - bus_data=0, grant_id=0, rr_ptr=0;
  - req_ready=0.
REQ-027 Reset asserted in HOLD SHALL discard the held beat. No req_ready SHALL pulse during reset or on the first edge after release unless a load condition is met.
REQ-028 After rst_n deasserts, the first arbitration SHALL start from requester 0.

Verification
REQ-029 Single requester:
  - stimulus: after reset, req_valid=4'b0100, req_data[2]=8'hAA, bus_ready=1;
  - response: req_ready=4'b0100 in cycle 0; bus_valid=1, bus_data=8'hAA, grant_id=2 in cycle 1; rr_ptr=3.
REQ-030 All requesting, round-robin order:
  - stimulus: req_valid=4'b1111 held, bus_ready=1, data per requester 8'h10/8'h11/8'h12/8'h13;
  - response: grants 0,1,2,3,0 on consecutive cycles; bus_data sequence 8'h10,8'h11,8'h12,8'h13,8'h10.
REQ-031 Backpressure:
  - stimulus: beat 8'h55 held, bus_ready=0 for 5 cycles;
  - response: bus_data=8'h55 and bus_valid=1 stable, req_ready=0 throughout; next beat loads on the cycle bus_ready=1.
REQ-032 Wrap and skip:
  - stimulus: rr_ptr=3, req_valid=4'b0010;
  - response: grant 1, rr_ptr=2.
  - stimulus: rr_ptr=3, req_valid=4'b1001;
  - response: grant 3, rr_ptr=0.
REQ-033 Drain to IDLE:
  - stimulus: HOLD, bus_ready=1, req_valid=0;
  - response: bus_valid=0 next cycle; bus_data retains its value.
REQ-034 Reset mid-transfer:
  - stimulus: rst_n=0 asserted mid-cycle in HOLD with bus_ready=0;
  - response: bus_valid=0, grant_id=0 immediately, with no clock edge; after release with req_valid=4'b1010, requester 1 wins first.
